// File: rtl/ieee754_pkg.sv
// Shared IEEE754 single-precision field layout, classification and constants
// used by the float-to-fixed converter.
package ieee754_pkg;

  localparam int FP_BIAS   = 127;
  localparam int FP_EXP_W  = 8;
  localparam int FP_FRAC_W = 23;

  typedef struct packed {
    logic                 sign;
    logic [FP_EXP_W-1:0]  exp;
    logic [FP_FRAC_W-1:0] frac;
  } fp32_t;

  typedef enum logic [1:0] {
    ZERO,
    NORMAL,
    INF,
    NAN
  } fp_class_e;

  // Denormals are deliberately folded into ZERO (flush-to-zero).
  function automatic fp_class_e fp_classify(input fp32_t f);
    fp_class_e c;
    if (f.exp == '0) begin
      c = ZERO;
    end else if (f.exp == '1) begin
      if (f.frac != '0) c = NAN;
      else              c = INF;
    end else begin
      c = NORMAL;
    end
    return c;
  endfunction

endpackage

// File: rtl/ieee754_to_fixed_barrel_shift.sv
// Bidirectional shift of the 24-bit significand into the magnitude domain.
// With IEEE754_TO_FIXED_ROUND_NEAREST_EN the bits lost on a right shift are
// summarised as guard/sticky for the rounding stage.
module fx_barrel_shift #(
  parameter int MAG_W = 33
) (
  input  logic               [23:0]      m,
  input  logic signed        [11:0]      sh,
  output logic               [MAG_W-1:0] mag
`ifdef IEEE754_TO_FIXED_ROUND_NEAREST_EN
  ,
  output logic                           guard,
  output logic                           sticky
`endif
);

  int                 lamt;
  int                 ramt;
  logic [MAG_W-1:0]   lmag;
  logic [23:0]        rmag;

  // Right-shift distance is clamped so a tiny value still leaves sticky set.
  always_comb begin
    lamt = 0;
    ramt = 0;
    if (sh >= 0) lamt = int'(sh);
    else         ramt = (-int'(sh) > 47) ? 47 : -int'(sh);
  end

  assign lmag = MAG_W'(m) << lamt;

`ifdef IEEE754_TO_FIXED_ROUND_NEAREST_EN
  logic [47:0] rwide;
  assign rwide  = {m, 24'd0} >> ramt;
  assign rmag   = rwide[47:24];
  assign guard  = (sh < 0) && rwide[23];
  assign sticky = (sh < 0) && (|rwide[22:0]);
`else
  assign rmag = m >> ramt;
`endif

  assign mag = (sh >= 0) ? lmag : MAG_W'(rmag);

endmodule

// File: rtl/ieee754_to_fixed.sv
// IEEE754 single -> signed fixed point (F_BITS fraction), 3-stage pipeline with
// valid/ready stall, saturation and NaN flag. Optional: IEEE754_TO_FIXED_ROUND_NEAREST_EN.
module ieee754_to_fixed
  import ieee754_pkg::*;
#(
  parameter int W      = 32,
  parameter int F_BITS = 18
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         a,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [W-1:0] y,
  output logic                ovf,
  output logic                nan
);

  localparam int                    MAG_W   = W + 1;
  localparam logic [MAG_W-1:0]      MAG_LIM = MAG_W'(1) << (W - 1);
  localparam logic signed [W-1:0]   Y_MAX   = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0]   Y_MIN   = {1'b1, {(W-1){1'b0}}};
  localparam logic signed [11:0]    EF_LIM  = 12'(W - 1);

  logic  stall;
  fp32_t fa;

  assign fa       = fp32_t'(a);
  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;

  function automatic logic mag_over(input logic sign, input logic [MAG_W-1:0] mag);
    return sign ? (mag > MAG_LIM) : (mag >= MAG_LIM);
  endfunction

`ifdef IEEE754_TO_FIXED_ROUND_NEAREST_EN
  function automatic logic [MAG_W-1:0] round_mag(input logic [MAG_W-1:0] mag,
                                                 input logic g, input logic s);
    return mag + MAG_W'(g && (s || mag[0]));
  endfunction
`endif

  function automatic void saturate(input  fp_class_e         cls,
                                   input  logic              sign,
                                   input  logic              big,
                                   input  logic [MAG_W-1:0]  mag,
                                   output logic [W-1:0]      yv,
                                   output logic              ov,
                                   output logic              nv);
    yv = '0;
    ov = 1'b0;
    nv = 1'b0;
    case (cls)
      NAN:  nv = 1'b1;
      INF: begin
        ov = 1'b1;
        yv = sign ? Y_MIN : Y_MAX;
      end
      NORMAL: begin
        if (big || mag_over(sign, mag)) begin
          ov = 1'b1;
          yv = sign ? Y_MIN : Y_MAX;
        end else begin
          yv = sign ? W'(-mag) : W'(mag);
        end
      end
      default: yv = '0;
    endcase
  endfunction

  // ---- S1: unpack / classify ----
  logic               vld_p0;
  fp_class_e          cls_p0;
  logic               sign_p0;
  logic [23:0]        m_p0;
  logic signed [9:0]  e_p0;

  always_ff @(posedge clock) begin
    if (!resetn)     vld_p0 <= 1'b0;
    else if (!stall) vld_p0 <= in_valid;
  end

  always_ff @(posedge clock) begin
    if (!stall) begin
      cls_p0  <= fp_classify(fa);
      sign_p0 <= fa.sign;
      m_p0    <= {1'b1, fa.frac};
      e_p0    <= $signed({2'b00, fa.exp}) - $signed(10'(FP_BIAS));
    end
  end

  // ---- S2: align ----
  logic signed [11:0] ef_s2;
  logic signed [11:0] sh_s2;
  logic               big_s2;
  logic [MAG_W-1:0]   mag_s2;

  assign ef_s2 = $signed({{2{e_p0[9]}}, e_p0}) + $signed(12'(F_BITS));
  assign sh_s2 = ef_s2 - 12'sd23;
  // Exactly -2^(W-1) is representable, so it is carved out of the overflow test.
  assign big_s2 = (cls_p0 == NORMAL) && (ef_s2 >= EF_LIM) &&
                  !((ef_s2 == EF_LIM) && sign_p0 && (m_p0[FP_FRAC_W-1:0] == '0));

  logic               vld_p1;
  fp_class_e          cls_p1;
  logic               sign_p1;
  logic               big_p1;
  logic [MAG_W-1:0]   mag_p1;

`ifdef IEEE754_TO_FIXED_ROUND_NEAREST_EN
  logic guard_s2, sticky_s2, guard_p1, sticky_p1;

  fx_barrel_shift #(.MAG_W(MAG_W)) u_shift (
    .m      (m_p0),
    .sh     (sh_s2),
    .mag    (mag_s2),
    .guard  (guard_s2),
    .sticky (sticky_s2)
  );

  always_ff @(posedge clock) begin
    if (!stall) begin
      guard_p1  <= guard_s2;
      sticky_p1 <= sticky_s2;
    end
  end
`else
  fx_barrel_shift #(.MAG_W(MAG_W)) u_shift (
    .m   (m_p0),
    .sh  (sh_s2),
    .mag (mag_s2)
  );
`endif

  always_ff @(posedge clock) begin
    if (!resetn)     vld_p1 <= 1'b0;
    else if (!stall) vld_p1 <= vld_p0;
  end

  always_ff @(posedge clock) begin
    if (!stall) begin
      cls_p1  <= cls_p0;
      sign_p1 <= sign_p0;
      big_p1  <= big_s2;
      mag_p1  <= mag_s2;
    end
  end

  // ---- S3: round / sign / saturate ----
  logic [MAG_W-1:0] mag_s3;
  logic [W-1:0]     y_s3;
  logic             ovf_s3;
  logic             nan_s3;

`ifdef IEEE754_TO_FIXED_ROUND_NEAREST_EN
  assign mag_s3 = round_mag(mag_p1, guard_p1, sticky_p1);
`else
  assign mag_s3 = mag_p1;
`endif

  always_comb begin
    y_s3   = '0;
    ovf_s3 = 1'b0;
    nan_s3 = 1'b0;
    saturate(cls_p1, sign_p1, big_p1, mag_s3, y_s3, ovf_s3, nan_s3);
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      out_valid <= 1'b0;
      y         <= '0;
      ovf       <= 1'b0;
      nan       <= 1'b0;
    end else if (!stall) begin
      out_valid <= vld_p1;
      y         <= y_s3;
      ovf       <= ovf_s3;
      nan       <= nan_s3;
    end
  end

endmodule

// File: tb/tb_ieee754_to_fixed.sv
// Bench for ieee754_to_fixed (W=32, F_BITS=18): directed corner values, stall,
// mid-stream reset and a random stream against a real-arithmetic reference.
module tb_ieee754_to_fixed;

  localparam int W      = 32;
  localparam int F_BITS = 18;
`ifdef IEEE754_TO_FIXED_ROUND_NEAREST_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        resetn;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] y;
  logic        ovf;
  logic        nan;

  int ncmp  = 0;
  int nfail = 0;
  int chk_idx = 0;
  int base;
  logic [31:0] ra;

  logic [33:0] exp_q[$];
  logic [33:0] got_q[$];

  logic [31:0] tv_a [0:13];
  logic [31:0] tv_y [0:13];
  logic        tv_o [0:13];
  logic        tv_n [0:13];

  ieee754_to_fixed #(.W(W), .F_BITS(F_BITS)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .ovf       (ovf),
    .nan       (nan)
  );

  always #5 clock = ~clock;

  // Reference: exact real value scaled by 2^F_BITS, then truncated or rounded.
  function automatic logic [33:0] ref_model(input logic [31:0] x);
    int      ex;
    real     mg, fl, d;
    longint  v;
    logic    s;
    s  = x[31];
    ex = int'(x[30:23]);
    if (ex == 0) return 34'd0;
    if (ex == 255) begin
      if (x[22:0] != 0) return {32'd0, 1'b0, 1'b1};
      return {(s ? 32'h80000000 : 32'h7FFFFFFF), 1'b1, 1'b0};
    end
    mg = (1.0 + real'(x[22:0]) / 8388608.0) * (2.0 ** (ex - 127 + F_BITS));
    if (mg >= 2.0 ** 40) return {(s ? 32'h80000000 : 32'h7FFFFFFF), 1'b1, 1'b0};
    fl = $floor(mg);
    if (RND) begin
      d = mg - fl;
      if (d > 0.5 || (d == 0.5 && (longint'(fl) % 2) == 1)) fl = fl + 1.0;
    end
    v = longint'(fl);
    if (s) v = -v;
    if (v > 64'sd2147483647)  return {32'h7FFFFFFF, 1'b1, 1'b0};
    if (v < -64'sd2147483648) return {32'h80000000, 1'b1, 1'b0};
    return {v[31:0], 1'b0, 1'b0};
  endfunction

  always @(negedge clock) begin
    if (out_valid && out_ready) got_q.push_back({y, ovf, nan});
    if (!resetn) begin
      while (exp_q.size() > got_q.size()) void'(exp_q.pop_back());
    end
    if (resetn && in_valid && in_ready) exp_q.push_back(ref_model(a));
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    ncmp++;
    assert (obs === expv) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic drain_check();
    while (chk_idx < got_q.size()) begin
      if (chk_idx < exp_q.size())
        chk($sformatf("stream[%0d]", chk_idx), 64'(got_q[chk_idx]), 64'(exp_q[chk_idx]));
      else
        chk($sformatf("extra_out[%0d]", chk_idx), 64'(got_q[chk_idx]), 64'h0DEAD);
      chk_idx++;
    end
  endtask

  task automatic wait_drain(input string tag);
    for (int k = 0; k < 60; k++) begin
      if (got_q.size() >= exp_q.size() && !out_valid) break;
      @(posedge clock); #1;
    end
    chk(tag, 64'(got_q.size()), 64'(exp_q.size()));
  endtask

  task automatic run_one(input int i);
    int lat;
    lat = 0;
    a = tv_a[i];
    in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clock);
      if (out_valid) begin
        lat = k;
        break;
      end
    end
    chk($sformatf("lat_%h", tv_a[i]), 64'(lat), 64'd3);
    chk($sformatf("y_%h", tv_a[i]),   64'(y),   64'(tv_y[i]));
    chk($sformatf("ovf_%h", tv_a[i]), 64'(ovf), 64'(tv_o[i]));
    chk($sformatf("nan_%h", tv_a[i]), 64'(nan), 64'(tv_n[i]));
    @(posedge clock); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    tv_a[0]  = 32'h3F800000; tv_y[0]  = 32'h00040000; tv_o[0]  = 0; tv_n[0]  = 0;
    tv_a[1]  = 32'hC0200000; tv_y[1]  = 32'hFFF60000; tv_o[1]  = 0; tv_n[1]  = 0;
    tv_a[2]  = 32'h46000000; tv_y[2]  = 32'h7FFFFFFF; tv_o[2]  = 1; tv_n[2]  = 0;
    tv_a[3]  = 32'hC6000000; tv_y[3]  = 32'h80000000; tv_o[3]  = 0; tv_n[3]  = 0;
    tv_a[4]  = 32'hFF800000; tv_y[4]  = 32'h80000000; tv_o[4]  = 1; tv_n[4]  = 0;
    tv_a[5]  = 32'h7F800000; tv_y[5]  = 32'h7FFFFFFF; tv_o[5]  = 1; tv_n[5]  = 0;
    tv_a[6]  = 32'h7FC00000; tv_y[6]  = 32'h00000000; tv_o[6]  = 0; tv_n[6]  = 1;
    tv_a[7]  = 32'h80000000; tv_y[7]  = 32'h00000000; tv_o[7]  = 0; tv_n[7]  = 0;
    tv_a[8]  = 32'h00000001; tv_y[8]  = 32'h00000000; tv_o[8]  = 0; tv_n[8]  = 0;
    tv_a[9]  = 32'h36400000; tv_y[9]  = RND ? 32'd1 : 32'd0; tv_o[9] = 0; tv_n[9] = 0;
    tv_a[10] = 32'h36000000; tv_y[10] = 32'h00000000; tv_o[10] = 0; tv_n[10] = 0;
    tv_a[11] = 32'h36C00000; tv_y[11] = RND ? 32'd2 : 32'd1; tv_o[11] = 0; tv_n[11] = 0;
    tv_a[12] = 32'hC6000001; tv_y[12] = 32'h80000000; tv_o[12] = 1; tv_n[12] = 0;
    tv_a[13] = 32'h45FFFFFF; tv_y[13] = 32'h7FFFFF80; tv_o[13] = 0; tv_n[13] = 0;

    resetn = 1'b0; in_valid = 1'b0; a = '0; out_ready = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_y",         64'(y),         64'd0);
    chk("rst_ovf",       64'(ovf),       64'd0);
    chk("rst_nan",       64'(nan),       64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    @(posedge clock); #1;
    resetn = 1'b1;
    @(posedge clock); #1;

    // Directed corner values, one at a time.
    for (int i = 0; i <= 13; i++) run_one(i);
    drain_check();

    // Back-to-back stream with a 4-cycle consumer stall.
    base = got_q.size();
    out_ready = 1'b1;
    a = 32'h3F800000; in_valid = 1'b1; @(posedge clock); #1;
    a = 32'h40000000;                  @(posedge clock); #1;
    a = 32'h40400000;                  @(posedge clock); #1;
    a = 32'h40800000;
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      chk($sformatf("stall_in_ready%0d", k),  64'(in_ready),  64'd0);
      chk($sformatf("stall_out_valid%0d", k), 64'(out_valid), 64'd1);
      chk($sformatf("stall_y%0d", k),         64'(y),         64'h40000);
      @(posedge clock); #1;
    end
    out_ready = 1'b1;
    @(negedge clock);
    chk("unstall_in_ready", 64'(in_ready), 64'd1);
    @(posedge clock); #1;
    in_valid = 1'b0;
    wait_drain("stall_drain");
    chk("stall_count", 64'(got_q.size() - base), 64'd4);
    chk("stall_o0", 64'(got_q[base][33:2]),     64'h40000);
    chk("stall_o1", 64'(got_q[base + 1][33:2]), 64'h80000);
    chk("stall_o2", 64'(got_q[base + 2][33:2]), 64'hC0000);
    chk("stall_o3", 64'(got_q[base + 3][33:2]), 64'h100000);
    drain_check();

    // Reset with two items in flight.
    base = got_q.size();
    a = 32'h3F800000; in_valid = 1'b1; @(posedge clock); #1;
    a = 32'h40000000;                  @(posedge clock); #1;
    in_valid = 1'b0; resetn = 1'b0;
    @(posedge clock); #1;
    resetn = 1'b1;
    a = 32'h40400000; in_valid = 1'b1;
    @(negedge clock);
    chk("rstmid_out_valid", 64'(out_valid), 64'd0);
    chk("rstmid_y",         64'(y),         64'd0);
    chk("rstmid_in_ready",  64'(in_ready),  64'd1);
    @(posedge clock); #1;
    in_valid = 1'b0;
    wait_drain("rstmid_drain");
    chk("rstmid_count", 64'(got_q.size() - base), 64'd1);
    chk("rstmid_o0",    64'(got_q[base][33:2]),   64'hC0000);
    drain_check();

    // Random stream with random bubbles and consumer stalls.
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 7))
        0:       ra = $urandom();
        1:       ra = {1'($urandom_range(0, 1)), 8'hFF,
                       (($urandom_range(0, 1) == 1) ? 23'($urandom()) : 23'd0)};
        2:       ra = {1'($urandom_range(0, 1)), 8'($urandom_range(156, 159)), 23'($urandom())};
        default: ra = {1'($urandom_range(0, 1)), 8'($urandom_range(95, 165)), 23'($urandom())};
      endcase
      a         = ra;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clock); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_drain("rand_drain");
    drain_check();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
